pw_check_fsm: RTL

- Consumes the 128-bit digit buffer produced by the keypad entry register: 32 nibbles, unused positions 0xF, newest digit in the LSBs.
- On an enter command, compares the snapshot against the stored password. Opens the door for a timed window on match; counts failures and enforces a timed lockout after MAX_TRIES consecutive failures.
- Drives the entry register's synchronous clear (mem_rst) after each decision.
- Allows the password to be changed while the door is open.

---
 rtl/pw_check_if.sv | 26 ++
 rtl/pw_check_fsm.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pw_check_if.sv
// Keypad-to-lock interface: entry buffer and commands in, lock status and entry-clear out.
interface pw_check_if #(
  parameter int unsigned MAX_TRIES = 3
);
  localparam int unsigned AW = $clog2(MAX_TRIES + 1);

  logic [127:0]  entered_pw;
  logic          cmd_enter;
  logic          cmd_set;
  logic          mem_rst;
  logic          door_open;
  logic          fail;
  logic          locked_out;
  logic          set_ack;
  logic [AW-1:0] attempts;

  modport master (
    output entered_pw, cmd_enter, cmd_set,
    input  mem_rst, door_open, fail, locked_out, set_ack, attempts
  );

  modport slave (
    input  entered_pw, cmd_enter, cmd_set,
    output mem_rst, door_open, fail, locked_out, set_ack, attempts
  );
endinterface

// File: rtl/pw_check_fsm.sv
// Password check FSM: validates keypad entries, opens the door for a timed window,
// counts consecutive failures and enforces a timed lockout.
module pw_check_fsm #(
  parameter int unsigned  OPEN_CYCLES = 1000,
  parameter int unsigned  LOCK_CYCLES = 5000,
  parameter int unsigned  MAX_TRIES   = 3,
  parameter logic [127:0] DEFAULT_PW  = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFF1234
) (
  input  logic      clk,
  input  logic      rstn,
  pw_check_if.slave bus
);

  localparam int unsigned AW   = $clog2(MAX_TRIES + 1);
  localparam int unsigned TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_OPEN,
    S_FAIL,
    S_LOCKOUT
  } state_t;

  state_t         r_state;
  logic [127:0]   r_snapshot;
  logic [127:0]   r_stored_pw;
  logic [AW-1:0]  r_fail_cnt;
  logic [TW-1:0]  r_timer;
  logic           r_mem_rst;
  logic           r_door_open;
  logic           r_fail;
  logic           r_locked_out;
  logic           r_set_ack;

  logic           w_empty;
  logic           w_match;
  logic           w_timer_zero;

  assign w_empty      = &bus.entered_pw;
  assign w_match      = (r_snapshot == r_stored_pw);
  assign w_timer_zero = (r_timer == '0);

  // Outputs are registered alongside the state transition that implies them.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_snapshot   <= '1;
      r_stored_pw  <= DEFAULT_PW;
      r_fail_cnt   <= '0;
      r_timer      <= '0;
      r_mem_rst    <= 1'b0;
      r_door_open  <= 1'b0;
      r_fail       <= 1'b0;
      r_locked_out <= 1'b0;
      r_set_ack    <= 1'b0;
    end else begin
      r_mem_rst <= 1'b0;
      r_fail    <= 1'b0;
      r_set_ack <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.cmd_enter && !w_empty) begin
            r_snapshot <= bus.entered_pw;
            r_mem_rst  <= 1'b1;
            r_state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_match) begin
            r_state     <= S_OPEN;
            r_door_open <= 1'b1;
            r_fail_cnt  <= '0;
            r_timer     <= TW'(OPEN_CYCLES - 1);
          end else begin
            r_state <= S_FAIL;
            r_fail  <= 1'b1;
            if (r_fail_cnt != AW'(MAX_TRIES)) r_fail_cnt <= r_fail_cnt + AW'(1);
          end
        end
        S_FAIL: begin
          if (r_fail_cnt == AW'(MAX_TRIES)) begin
            r_state      <= S_LOCKOUT;
            r_locked_out <= 1'b1;
            r_mem_rst    <= 1'b1;
            r_timer      <= TW'(LOCK_CYCLES - 1);
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOCKOUT: begin
          // Entry buffer is held clear for every lockout cycle, including the last.
          if (w_timer_zero) begin
            r_state      <= S_IDLE;
            r_locked_out <= 1'b0;
            r_fail_cnt   <= '0;
          end else begin
            r_timer   <= r_timer - TW'(1);
            r_mem_rst <= 1'b1;
          end
        end
        S_OPEN: begin
          // A valid set takes priority over a close request in the same cycle.
          if (bus.cmd_set && !w_empty) begin
            r_stored_pw <= bus.entered_pw;
            r_set_ack   <= 1'b1;
            r_mem_rst   <= 1'b1;
            r_timer     <= TW'(OPEN_CYCLES - 1);
          end else if (bus.cmd_enter) begin
            r_state     <= S_IDLE;
            r_door_open <= 1'b0;
            r_mem_rst   <= 1'b1;
          end else if (w_timer_zero) begin
            r_state     <= S_IDLE;
            r_door_open <= 1'b0;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_door_open  <= 1'b0;
          r_locked_out <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_rst    = r_mem_rst;
  assign bus.door_open  = r_door_open;
  assign bus.fail       = r_fail;
  assign bus.locked_out = r_locked_out;
  assign bus.set_ack    = r_set_ack;
  assign bus.attempts   = r_fail_cnt;

endmodule
